// File: rtl/draw_pkg.sv
// Shared types and helpers for the 2-D drawing pipeline span writer.
package draw_pkg;

  localparam int unsigned PIX_PER_WORD = 4;
  localparam int unsigned BPP          = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCUM,
    ST_WRITE
  } state_t;

  // Nibble 0 occupies bits 15:12, so it is enabled by the top mask bit.
  function automatic logic [PIX_PER_WORD-1:0] nib_mask(input logic [1:0] nib);
    return 4'b1000 >> nib;
  endfunction

  function automatic logic [PIX_PER_WORD*BPP-1:0] fill_data(
    input logic [PIX_PER_WORD-1:0] mask,
    input logic [BPP-1:0]          color
  );
    logic [PIX_PER_WORD*BPP-1:0] d;
    d = '0;
    for (int unsigned i = 0; i < PIX_PER_WORD; i++) begin
      if (mask[i]) d[i*BPP +: BPP] = color;
    end
    return d;
  endfunction

endpackage

// File: rtl/draw_pixel_addr.sv
// Combinational pixel-to-word mapping: clip test, word address and nibble select.
module draw_pixel_addr
  import draw_pkg::*;
#(
  parameter int CORDW = 16,
  parameter int ADDRW = 16
) (
  input  logic signed [CORDW-1:0] i_x,
  input  logic [ADDRW-1:0]        i_line_addr,
  input  logic [ADDRW-1:0]        i_width_words,
  output logic                    o_clip,
  output logic [ADDRW-1:0]        o_word_addr,
  output logic [1:0]              o_nib
);

  localparam int CW = (CORDW > ADDRW) ? CORDW : ADDRW;

  logic [CORDW-1:0] w_xu;
  logic [CW-1:0]    w_off;
  logic [CW-1:0]    w_wid;

  assign w_xu  = $unsigned(i_x) >> 2;
  assign w_off = CW'(w_xu);
  assign w_wid = CW'(i_width_words);

  assign o_clip      = i_x[CORDW-1] || (w_off >= w_wid);
  assign o_word_addr = i_line_addr + ADDRW'(w_xu);
  assign o_nib       = i_x[1:0];

endmodule

// File: rtl/draw_span_writer.sv
// Packs stepper pixels of one span into nibble-masked VRAM word writes,
// merging same-word pixels and stalling the stepper while a write is pending.
module draw_span_writer
  import draw_pkg::*;
#(
  parameter int CORDW = 16,
  parameter int ADDRW = 16
) (
  input  logic                    clk,
  input  logic                    reset_i,
  input  logic                    start_i,
  input  logic [ADDRW-1:0]        base_addr_i,
  input  logic [ADDRW-1:0]        width_words_i,
  input  logic signed [CORDW-1:0] y_i,
  input  logic [3:0]              color_i,
  input  logic signed [CORDW-1:0] x_i,
  input  logic                    drawing_i,
  input  logic                    done_i,
  output logic                    oe_o,
  output logic                    vram_wr_o,
  output logic [ADDRW-1:0]        vram_addr_o,
  output logic [15:0]             vram_data_o,
  output logic [3:0]              vram_mask_o,
  input  logic                    vram_ack_i,
  output logic                    busy_o,
  output logic                    done_o
);

  state_t                  r_state, w_state_n;
  logic [ADDRW-1:0]        r_base, w_base_n, r_width, w_width_n;
  logic [ADDRW-1:0]        r_line_addr, w_line_addr_n;
  logic signed [CORDW-1:0] r_y, w_y_n;
  logic [3:0]              r_color, w_color_n;
  logic                    r_yclip, w_yclip_n, r_end_pending, w_end_pending_n;
  logic                    r_acc_valid, w_acc_valid_n;
  logic [ADDRW-1:0]        r_acc_addr, w_acc_addr_n;
  logic [3:0]              r_acc_mask, w_acc_mask_n;
  logic                    r_wr, w_wr_n;
  logic [ADDRW-1:0]        r_addr, w_addr_n;
  logic [15:0]             r_data, w_data_n;
  logic [3:0]              r_mask, w_mask_n;
  logic                    r_busy, w_busy_n, r_done, w_done_n;

  logic                    w_clip, w_pix, w_split, w_end;
  logic [ADDRW-1:0]        w_word;
  logic [1:0]              w_nib;
  logic                    w_mrg_valid;
  logic [ADDRW-1:0]        w_mrg_addr;
  logic [3:0]              w_mrg_mask;

  draw_pixel_addr #(.CORDW(CORDW), .ADDRW(ADDRW)) u_pix (
    .i_x           (x_i),
    .i_line_addr   (r_line_addr),
    .i_width_words (r_width),
    .o_clip        (w_clip),
    .o_word_addr   (w_word),
    .o_nib         (w_nib)
  );

  // Accumulator as it would look after absorbing this cycle's pixel.
  assign w_pix       = drawing_i && !r_yclip && !w_clip;
  assign w_split     = w_pix && r_acc_valid && (w_word != r_acc_addr);
  assign w_end       = done_i || r_end_pending;
  assign w_mrg_valid = r_acc_valid || w_pix;
  assign w_mrg_addr  = w_pix ? w_word : r_acc_addr;
  assign w_mrg_mask  = (r_acc_valid ? r_acc_mask : '0) | (w_pix ? nib_mask(w_nib) : '0);

  always_comb begin
    w_state_n       = r_state;
    w_base_n        = r_base;
    w_width_n       = r_width;
    w_line_addr_n   = r_line_addr;
    w_y_n           = r_y;
    w_color_n       = r_color;
    w_yclip_n       = r_yclip;
    w_end_pending_n = r_end_pending;
    w_acc_valid_n   = r_acc_valid;
    w_acc_addr_n    = r_acc_addr;
    w_acc_mask_n    = r_acc_mask;
    w_wr_n          = r_wr;
    w_addr_n        = r_addr;
    w_data_n        = r_data;
    w_mask_n        = r_mask;
    w_busy_n        = r_busy;
    w_done_n        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          w_base_n        = base_addr_i;
          w_width_n       = width_words_i;
          w_y_n           = y_i;
          w_color_n       = color_i;
          w_end_pending_n = 1'b0;
          w_busy_n        = 1'b1;
          w_state_n       = ST_SETUP;
        end
      end
      ST_SETUP: begin
        w_line_addr_n   = r_base + ADDRW'($unsigned(r_y)) * r_width;
        w_yclip_n       = r_y[CORDW-1];
        w_acc_valid_n   = 1'b0;
        w_acc_mask_n    = '0;
        w_end_pending_n = r_end_pending | done_i;
        w_state_n       = ST_ACCUM;
      end
      ST_ACCUM: begin
        if (w_split) begin
          w_wr_n          = 1'b1;
          w_addr_n        = r_acc_addr;
          w_mask_n        = r_acc_mask;
          w_data_n        = fill_data(r_acc_mask, r_color);
          w_acc_addr_n    = w_word;
          w_acc_mask_n    = nib_mask(w_nib);
          w_end_pending_n = w_end;
          w_state_n       = ST_WRITE;
        end else if (w_end && w_mrg_valid) begin
          w_wr_n          = 1'b1;
          w_addr_n        = w_mrg_addr;
          w_mask_n        = w_mrg_mask;
          w_data_n        = fill_data(w_mrg_mask, r_color);
          w_acc_valid_n   = 1'b0;
          w_acc_mask_n    = '0;
          w_end_pending_n = 1'b1;
          w_state_n       = ST_WRITE;
        end else if (w_end) begin
          w_done_n        = 1'b1;
          w_busy_n        = 1'b0;
          w_end_pending_n = 1'b0;
          w_state_n       = ST_IDLE;
        end else begin
          w_acc_valid_n   = w_mrg_valid;
          w_acc_addr_n    = w_mrg_addr;
          w_acc_mask_n    = w_mrg_mask;
        end
      end
      ST_WRITE: begin
        w_end_pending_n = r_end_pending | done_i;
        if (vram_ack_i) begin
          w_wr_n = 1'b0;
          if (!r_end_pending) begin
            w_state_n = ST_ACCUM;
          end else if (r_acc_valid) begin
            // Flush the remaining word back-to-back without revisiting ACCUM.
            w_wr_n        = 1'b1;
            w_addr_n      = r_acc_addr;
            w_mask_n      = r_acc_mask;
            w_data_n      = fill_data(r_acc_mask, r_color);
            w_acc_valid_n = 1'b0;
            w_acc_mask_n  = '0;
          end else begin
            w_done_n        = 1'b1;
            w_busy_n        = 1'b0;
            w_end_pending_n = 1'b0;
            w_state_n       = ST_IDLE;
          end
        end
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_state       <= ST_IDLE;
      r_base        <= '0;
      r_width       <= '0;
      r_line_addr   <= '0;
      r_y           <= '0;
      r_color       <= '0;
      r_yclip       <= 1'b0;
      r_end_pending <= 1'b0;
      r_acc_valid   <= 1'b0;
      r_acc_addr    <= '0;
      r_acc_mask    <= '0;
      r_wr          <= 1'b0;
      r_addr        <= '0;
      r_data        <= '0;
      r_mask        <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_state_n;
      r_base        <= w_base_n;
      r_width       <= w_width_n;
      r_line_addr   <= w_line_addr_n;
      r_y           <= w_y_n;
      r_color       <= w_color_n;
      r_yclip       <= w_yclip_n;
      r_end_pending <= w_end_pending_n;
      r_acc_valid   <= w_acc_valid_n;
      r_acc_addr    <= w_acc_addr_n;
      r_acc_mask    <= w_acc_mask_n;
      r_wr          <= w_wr_n;
      r_addr        <= w_addr_n;
      r_data        <= w_data_n;
      r_mask        <= w_mask_n;
      r_busy        <= w_busy_n;
      r_done        <= w_done_n;
    end
  end

  assign oe_o        = (r_state == ST_ACCUM);
  assign vram_wr_o   = r_wr;
  assign vram_addr_o = r_addr;
  assign vram_data_o = r_data;
  assign vram_mask_o = r_mask;
  assign busy_o      = r_busy;
  assign done_o      = r_done;

endmodule

// File: tb/tb_draw_span_writer.sv
// Bench for draw_span_writer: directed spans plus randomized spans vs. a reference model.
module tb_draw_span_writer;

  logic               clk = 1'b0;
  logic               reset_i = 1'b1;
  logic               start_i = 1'b0;
  logic [15:0]        base_addr_i = '0;
  logic [15:0]        width_words_i = '0;
  logic signed [15:0] y_i = '0;
  logic [3:0]         color_i = '0;
  logic signed [15:0] x_i = '0;
  logic               drawing_i = 1'b0;
  logic               done_i = 1'b0;
  logic               oe_o, vram_wr_o, busy_o, done_o;
  logic [15:0]        vram_addr_o, vram_data_o;
  logic [3:0]         vram_mask_o;
  logic               vram_ack_i = 1'b0;

  always #5 clk = ~clk;

  draw_span_writer #(.CORDW(16), .ADDRW(16)) dut (
    .clk           (clk),
    .reset_i       (reset_i),
    .start_i       (start_i),
    .base_addr_i   (base_addr_i),
    .width_words_i (width_words_i),
    .y_i           (y_i),
    .color_i       (color_i),
    .x_i           (x_i),
    .drawing_i     (drawing_i),
    .done_i        (done_i),
    .oe_o          (oe_o),
    .vram_wr_o     (vram_wr_o),
    .vram_addr_o   (vram_addr_o),
    .vram_data_o   (vram_data_o),
    .vram_mask_o   (vram_mask_o),
    .vram_ack_i    (vram_ack_i),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  typedef struct {
    logic [15:0] addr;
    logic [3:0]  mask;
    logic [15:0] data;
  } wr_t;

  wr_t         got_q[$];
  wr_t         exp_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int          done_cnt = 0;
  int          wr_cycles = 0;
  int          ack_min = 0;
  int          ack_max = 0;
  bit          ack_never = 1'b0;
  int          ack_wait = 0;
  bit          prev_valid = 1'b0;
  logic [15:0] prev_addr, prev_data;
  logic [3:0]  prev_mask;

  // VRAM responder and request monitor; a write is logged when it is acked.
  always @(negedge clk) begin
    if (reset_i) begin
      prev_valid = 1'b0;
      vram_ack_i = 1'b0;
    end else begin
      if (done_o) done_cnt++;
      if (vram_wr_o) wr_cycles++;
      if (prev_valid) begin
        n_cmp++;
        if (vram_wr_o !== 1'b1 || vram_addr_o !== prev_addr || vram_data_o !== prev_data ||
            vram_mask_o !== prev_mask) begin
          n_bad++;
          $display("FAIL req_stable: got wr=%b a=%h d=%h m=%b want wr=1 a=%h d=%h m=%b",
                   vram_wr_o, vram_addr_o, vram_data_o, vram_mask_o, prev_addr, prev_data, prev_mask);
        end
      end
      if (vram_wr_o) begin
        n_cmp++;
        if (oe_o !== 1'b0) begin
          n_bad++;
          $display("FAIL oe_in_write: got oe=%b want 0", oe_o);
        end
      end
      prev_valid = 1'b0;
      if (!vram_wr_o || ack_never) begin
        vram_ack_i = 1'b0;
        ack_wait = $urandom_range(ack_max, ack_min);
      end else if (vram_ack_i) begin
        vram_ack_i = 1'b0;
        ack_wait = $urandom_range(ack_max, ack_min);
      end else if (ack_wait == 0) begin
        vram_ack_i = 1'b1;
        got_q.push_back('{vram_addr_o, vram_mask_o, vram_data_o});
      end else begin
        ack_wait--;
      end
      if (vram_wr_o && !vram_ack_i) begin
        prev_valid = 1'b1;
        prev_addr  = vram_addr_o;
        prev_data  = vram_data_o;
        prev_mask  = vram_mask_o;
      end
    end
  end

  // Expected writes: runs of consecutive visible pixels sharing one word.
  task automatic build_model(input int base, input int width, input int y, input int color,
                             input int xs, input int xe);
    int  line, w, cur_w, m;
    bit  have;
    exp_q.delete();
    have = 0; cur_w = 0; m = 0;
    line = (base + y * width) % 65536;
    for (int x = xs; x <= xe; x++) begin
      if (y < 0 || x < 0 || (x / 4) >= width) continue;
      w = (line + x / 4) % 65536;
      if (have && w == cur_w) begin
        m = m | (8 >> (x % 4));
      end else begin
        if (have) exp_q.push_back('{16'(cur_w), 4'(m), 16'h0});
        cur_w = w; m = 8 >> (x % 4); have = 1;
      end
    end
    if (have) exp_q.push_back('{16'(cur_w), 4'(m), 16'h0});
    foreach (exp_q[i]) begin
      for (int b = 0; b < 4; b++)
        if (exp_q[i].mask[b]) exp_q[i].data = exp_q[i].data | 16'(color << (4 * b));
    end
  endtask

  task automatic start_span(input int base, input int width, input int y, input int color);
    @(negedge clk);
    base_addr_i = 16'(base); width_words_i = 16'(width); y_i = 16'(y); color_i = 4'(color);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  // Stepper emulation; returns negedges from done_i until done_o is seen (0 on timeout).
  task automatic run_span(input int xs, input int xe, input int gap_pct, output int lat);
    int cur, cyc;
    cur = xs; cyc = 0;
    while (cur <= xe && cyc < 2000) begin
      @(negedge clk);
      if ($urandom_range(99, 0) < gap_pct) begin
        drawing_i = 1'b0;
      end else begin
        drawing_i = 1'b1;
        x_i = 16'(cur);
        if (oe_o) cur++;
      end
      cyc++;
    end
    @(negedge clk);
    drawing_i = 1'b0; done_i = 1'b1;
    @(negedge clk);
    done_i = 1'b0;
    lat = 1;
    while (done_o !== 1'b1 && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
    if (done_o !== 1'b1) lat = 0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({oe_o, vram_wr_o, busy_o, done_o, vram_addr_o, vram_data_o, vram_mask_o} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got oe=%b wr=%b busy=%b done=%b a=%h d=%h m=%b want all 0",
               oe_o, vram_wr_o, busy_o, done_o, vram_addr_o, vram_data_o, vram_mask_o);
    end
    reset_i = 1'b0;
  endtask

  task automatic test_merge_split();
    int lat;
    got_q.delete();
    start_span(16'h1000, 80, 2, 4'hA);
    n_cmp++;
    if (busy_o !== 1'b1 || oe_o !== 1'b0) begin
      n_bad++; $display("FAIL start_setup: got busy=%b oe=%b want busy=1 oe=0", busy_o, oe_o);
    end
    @(negedge clk);
    n_cmp++;
    if (oe_o !== 1'b1) begin n_bad++; $display("FAIL start_oe_latency: got oe=%b want 1", oe_o); end
    run_span(1, 6, 0, lat);
    n_cmp++;
    if (lat == 0 || busy_o !== 1'b0) begin
      n_bad++; $display("FAIL merge_done: got lat=%0d busy=%b want lat>0 busy=0", lat, busy_o);
    end
    @(negedge clk);
    n_cmp++;
    if (done_o !== 1'b0) begin n_bad++; $display("FAIL done_pulse_width: got done=%b want 0", done_o); end
    n_cmp++;
    if (got_q.size() != 2) begin
      n_bad++; $display("FAIL merge_count: got %0d writes want 2", got_q.size());
    end else begin
      n_cmp++;
      if (got_q[0].addr !== 16'h10A0 || got_q[0].mask !== 4'b0111 || got_q[0].data !== 16'h0AAA) begin
        n_bad++; $display("FAIL merge_w0: got a=%h m=%b d=%h want a=10a0 m=0111 d=0aaa",
                          got_q[0].addr, got_q[0].mask, got_q[0].data);
      end
      n_cmp++;
      if (got_q[1].addr !== 16'h10A1 || got_q[1].mask !== 4'b1110 || got_q[1].data !== 16'hAAA0) begin
        n_bad++; $display("FAIL merge_w1: got a=%h m=%b d=%h want a=10a1 m=1110 d=aaa0",
                          got_q[1].addr, got_q[1].mask, got_q[1].data);
      end
    end
  endtask

  task automatic test_clip_lr();
    int lat;
    for (int t = 0; t < 2; t++) begin
      got_q.delete();
      start_span(16'h1000, 80, 2, 4'hA);
      if (t == 0) run_span(-3, 2, 0, lat);
      else        run_span(318, 321, 0, lat);
      n_cmp++;
      if (got_q.size() != 1 || lat == 0) begin
        n_bad++; $display("FAIL clip_count_%0d: got %0d writes lat=%0d want 1 write", t, got_q.size(), lat);
      end else if (t == 0) begin
        n_cmp++;
        if (got_q[0].addr !== 16'h10A0 || got_q[0].mask !== 4'b1110 || got_q[0].data !== 16'hAAA0) begin
          n_bad++; $display("FAIL left_clip: got a=%h m=%b d=%h want a=10a0 m=1110 d=aaa0",
                            got_q[0].addr, got_q[0].mask, got_q[0].data);
        end
      end else begin
        n_cmp++;
        if (got_q[0].addr !== 16'h10EF || got_q[0].mask !== 4'b0011 || got_q[0].data !== 16'h00AA) begin
          n_bad++; $display("FAIL right_clip: got a=%h m=%b d=%h want a=10ef m=0011 d=00aa",
                            got_q[0].addr, got_q[0].mask, got_q[0].data);
        end
      end
    end
  endtask

  task automatic test_neg_y();
    int lat, w0;
    got_q.delete();
    w0 = wr_cycles;
    start_span(16'h1000, 80, -1, 4'h5);
    run_span(0, 7, 0, lat);
    n_cmp++;
    if (wr_cycles != w0 || got_q.size() != 0) begin
      n_bad++; $display("FAIL neg_y_writes: got %0d wr cycles want 0", wr_cycles - w0);
    end
    n_cmp++;
    if (lat != 1 || busy_o !== 1'b0) begin
      n_bad++; $display("FAIL neg_y_done: got lat=%0d busy=%b want lat=1 busy=0", lat, busy_o);
    end
  endtask

  task automatic test_ack_hold();
    int lat;
    got_q.delete();
    ack_min = 5; ack_max = 5;
    start_span(16'h1000, 80, 2, 4'h3);
    run_span(1, 4, 0, lat);
    ack_min = 0; ack_max = 0;
    n_cmp++;
    if (got_q.size() != 2 || lat == 0) begin
      n_bad++; $display("FAIL ack_hold_count: got %0d writes lat=%0d want 2", got_q.size(), lat);
    end else begin
      n_cmp++;
      if (got_q[0].addr !== 16'h10A0 || got_q[0].mask !== 4'b0111 || got_q[0].data !== 16'h0333 ||
          got_q[1].addr !== 16'h10A1 || got_q[1].mask !== 4'b1000 || got_q[1].data !== 16'h3000) begin
        n_bad++; $display("FAIL ack_hold_data: got %h/%b/%h %h/%b/%h want 10a0/0111/0333 10a1/1000/3000",
                          got_q[0].addr, got_q[0].mask, got_q[0].data,
                          got_q[1].addr, got_q[1].mask, got_q[1].data);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    int cyc, d0, lat, cur;
    ack_never = 1'b1;
    start_span(16'h1000, 80, 2, 4'hA);
    cyc = 0; cur = 0;
    while (vram_wr_o !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      drawing_i = 1'b1; x_i = 16'(cur);
      if (oe_o) cur++;
      cyc++;
    end
    n_cmp++;
    if (vram_wr_o !== 1'b1) begin n_bad++; $display("FAIL mid_write_reach: got wr=%b want 1", vram_wr_o); end
    reset_i = 1'b1; drawing_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({oe_o, vram_wr_o, busy_o, done_o, vram_addr_o, vram_data_o, vram_mask_o} !== '0) begin
      n_bad++;
      $display("FAIL mid_write_reset: got oe=%b wr=%b busy=%b done=%b a=%h d=%h m=%b want all 0",
               oe_o, vram_wr_o, busy_o, done_o, vram_addr_o, vram_data_o, vram_mask_o);
    end
    reset_i = 1'b0; ack_never = 1'b0;
    d0 = done_cnt;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (done_cnt != d0) begin n_bad++; $display("FAIL mid_write_nodone: got %0d done pulses want 0", done_cnt - d0); end
    got_q.delete();
    start_span(16'h1000, 80, 2, 4'hA);
    run_span(1, 6, 0, lat);
    n_cmp++;
    if (got_q.size() != 2 || lat == 0 || got_q[0].addr !== 16'h10A0 || got_q[1].mask !== 4'b1110) begin
      n_bad++; $display("FAIL after_reset_span: got %0d writes lat=%0d want 2 writes 10a0.. then 1110",
                        got_q.size(), lat);
    end
  endtask

  task automatic test_random();
    int base, width, y, color, xs, xe, lat;
    for (int n = 0; n < 40; n++) begin
      base  = $urandom_range(65535, 0);
      width = $urandom_range(100, 1);
      y     = int'($urandom_range(22, 0)) - 2;
      color = $urandom_range(15, 0);
      xs    = int'($urandom_range(width * 4 + 16, 0)) - 8;
      xe    = xs + int'($urandom_range(20, 0)) - 1;
      ack_min = 0; ack_max = $urandom_range(3, 0);
      build_model(base, width, y, color, xs, xe);
      got_q.delete();
      start_span(base, width, y, color);
      run_span(xs, xe, 30, lat);
      n_cmp++;
      if (lat == 0 || busy_o !== 1'b0) begin
        n_bad++; $display("FAIL rand_done_%0d: got lat=%0d busy=%b want done with busy=0", n, lat, busy_o);
      end
      n_cmp++;
      if (got_q.size() != exp_q.size()) begin
        n_bad++; $display("FAIL rand_count_%0d: got %0d writes want %0d", n, got_q.size(), exp_q.size());
      end else begin
        foreach (exp_q[i]) begin
          n_cmp++;
          if (got_q[i].addr !== exp_q[i].addr || got_q[i].mask !== exp_q[i].mask ||
              got_q[i].data !== exp_q[i].data) begin
            n_bad++; $display("FAIL rand_w_%0d_%0d: got a=%h m=%b d=%h want a=%h m=%b d=%h", n, i,
                              got_q[i].addr, got_q[i].mask, got_q[i].data,
                              exp_q[i].addr, exp_q[i].mask, exp_q[i].data);
          end
        end
      end
    end
    ack_max = 0;
  endtask

  initial begin
    test_reset();
    test_merge_split();
    test_clip_lr();
    test_neg_y();
    test_ack_hold();
    test_reset_mid_write();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/draw_span_writer.md
# draw_span_writer

Downstream consumer of the 1-D span stepper in the 2-D drawing pipeline. Takes the stepper's per-cycle x positions for one horizontal span at row `y_i` and packs 4-bpp pixels into nibble-masked 16-bit VRAM write requests. It applies clipping, merges adjacent pixels that fall in the same word, and back-pressures the stepper through `oe_o` while a write is outstanding.

## Interface
- `CORDW`, 16, signed coordinate width (matches stepper)
- `ADDRW`, 16, VRAM word-address width

- `clk`  in  1  clock
- `reset_i`  in  1  reset; synchronous, active-high
- `start_i`  in  1  latch span setup; honoured only in IDLE
- `base_addr_i`  in  ADDRW  VRAM word address of row 0
- `width_words_i`  in  ADDRW  words per row (4 pixels/word)
- `y_i`  in  CORDW signed  span row
- `color_i`  in  4  pixel colour
- `x_i`  in  CORDW signed  stepper position
- `drawing_i`  in  1  `x_i` valid this cycle
- `done_i`  in  1  stepper finished (1-cycle pulse)
- `oe_o`  out  1  output enable to stepper
- `vram_wr_o`  out  1  write request, held until ack
- `vram_addr_o`  out  ADDRW  word address
- `vram_data_o`  out  16  write data
- `vram_mask_o`  out  4  nibble mask
- `vram_ack_i`  in  1  write accepted
- `busy_o`  out  1  span in progress
- `done_o`  out  1  span complete, 1-cycle pulse

## Operation
- Pixel mapping:
  - word = `line_addr + (x>>2)`
  - nibble n = `x[1:0]`; nibble 0 = bits 15:12, written via `mask[3-n]`
  - all address arithmetic is modulo 2^ADDRW
- Clipping: drop the pixel (consumed, no write) when `y_i<0`, `x<0`, or `(x>>2) >= width_words_i`, unsigned compare.
- States:
  - **IDLE**: on `start_i`, latch all setup inputs, set `busy_o=1`, go to SETUP.
  - **SETUP**: `line_addr <= base + y*width_words`, truncated to ADDRW; register the y-clip flag; clear accumulator; go to ACCUM.
  - **ACCUM**: `oe_o=1`. For each valid unclipped pixel:
    - If the accumulator is empty or the pixel is in the same word, OR its nibble into the accumulator.
    - Otherwise, copy the accumulator to the output registers, assert `vram_wr_o`, load the new pixel as the sole accumulator content, and go to WRITE.
  - End of span, on `done_i` or the latched `end_pending`:
    - Accumulator non-empty: issue its write and go to WRITE with `end_pending=1`.
    - Accumulator empty: pulse `done_o`, go to IDLE.
  - **WRITE**: `oe_o=0`. Hold `vram_wr/addr/data/mask` stable until `vram_ack_i`. On ack, drop `vram_wr_o`:
    - `end_pending` clear: return to ACCUM.
    - `end_pending` set, accumulator non-empty: issue the next write and stay in WRITE.
    - `end_pending` set, accumulator empty: pulse `done_o`, clear `busy_o`, go to IDLE.
- Data: the colour is replicated in every masked nibble. Unmasked nibbles are 0.
- `done_i` arriving in any non-IDLE state sets `end_pending`. It is never lost.
- A `drawing_i` pulse while `oe_o=0` is ignored. The stepper does not advance then.
- `start_i` outside IDLE is ignored.

## Timing
- Reset values: all outputs 0; state IDLE; accumulator, `end_pending` and the y-clip flag cleared.
- Reset mid-write drops the request immediately. No `done_o` is produced.
- `start_i` to first `oe_o=1`: 2 cycles (IDLE→SETUP→ACCUM).
- `vram_wr_o` rises on the edge after the word-change pixel or end condition. Minimum assertion is 1 cycle, when ack arrives in the first visible cycle.
- `oe_o` is combinational from state: low in IDLE, SETUP and WRITE.
- `done_o` is asserted on the edge after the final ack, or after `done_i` when nothing is pending. `busy_o` falls on the same edge.
- Fully clipped span: no writes; `done_o` 1 cycle after `done_i`.
- Throughput: one pixel per cycle while in ACCUM. Each word change costs at least 1 stall cycle.

## Structure
- Shared package `draw_pkg`:
  - state enum
  - `PIX_PER_WORD=4`, `BPP=4`
  - function mapping nibble index to mask bit
- Natural sub-module `draw_pixel_addr`: combinational clip test, word offset and nibble select from `x`, `line_addr` and `width_words`.
- The FSM and accumulator stay in `draw_span_writer`.

## Test plan
- Merge and split: base 0x1000, width 80, y=2, colour 0xA, span x 1..6, ack in 1 cycle. Expect two writes:
  - 0x10A0 mask 0111 data 0x0AAA
  - 0x10A1 mask 1110 data 0xAAA0
  - then one `done_o` pulse.
- Left clip: same setup, x −3..2. Expect a single write 0x10A0 mask 1110 data 0xAAA0.
- Right clip: x 318..321. Expect a single write 0x10EF mask 0011 data 0x00AA.
- Negative y=−1, x 0..7: no `vram_wr_o`; `done_o` pulses; `busy_o` falls.
- Ack held 5 cycles on the first write:
  - `oe_o` low for the full wait; request signals stable.
  - `done_i` arriving during WRITE still yields the final write, then `done_o`.
- Reset asserted while `vram_wr_o=1`: next cycle all outputs are 0, state is IDLE, and a new `start_i` works normally.
